// File: rtl/video_pkg.sv
// Shared video geometry defaults, unpacker state encoding, the 24-bit pixel type
// and the saturating error-counter update rule.
package video_pkg;
  localparam int unsigned X_SIZE_DEF = 640;
  localparam int unsigned Y_SIZE_DEF = 480;

  typedef enum logic [2:0] {WAIT_SOF, PH0, PH1, PH2, FLUSH} unpack_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  function automatic int unsigned words_per_line(input int unsigned x_size);
    return x_size * 3 / 4;
  endfunction

  // A new error in the clearing cycle leaves the count at one.
  function automatic logic [15:0] err_cnt_next(input logic [15:0] cnt, input logic clr,
                                               input logic hit);
    if (hit) return clr ? 16'd1 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
    return clr ? 16'd0 : cnt;
  endfunction
endpackage

// File: rtl/line_word_counter.sv
// Counts accepted words within a line; last_o marks that the next word should carry tlast.
// Registered count, combinational flag; no flow control of its own.
module line_word_counter #(
  parameter int unsigned WORDS = 480
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic sof_i,
  output logic last_o
);
  localparam int unsigned CW = (WORDS > 2) ? $clog2(WORDS) : 2;

  logic [CW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CW'(WORDS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      if (sof_i)       cnt_d = CW'(1);  // the frame-start word itself is word 0
      else if (last_o) cnt_d = '0;
      else             cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/stream_pixel_unpacker.sv
// Unpacks 3x32-bit words into 4 RGB888 pixels with x/y tagging; pixel one cycle after word accept,
// tready drops in FLUSH or while the output is stalled. UNPACKER_ERR_CNT_EN adds error counters.
module stream_pixel_unpacker
  import video_pkg::*;
#(
  parameter int unsigned X_SIZE = X_SIZE_DEF,
  parameter int unsigned Y_SIZE = Y_SIZE_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic        err_sof,
  output logic        err_eol,
  input  logic        clr_err
`ifdef UNPACKER_ERR_CNT_EN
  ,
  output logic [15:0] err_sof_cnt,
  output logic [15:0] err_eol_cnt
`endif
);
  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  unpack_state_e state_q, state_d;
  pixel_t        pix_q, pix_d, emit_pix;
  logic [23:0]   hold_q, hold_d;
  logic          pix_vld_q, pix_vld_d;
  logic [9:0]    x_q, x_d, cx_q, cx_d, pos_x;
  logic [8:0]    y_q, y_d, cy_q, cy_d, pos_y;
  logic          sof_q, sof_d, eol_q, eol_d;
  logic          frame_done_q, frame_done_d;
  logic          err_sof_q, err_sof_d, err_eol_q, err_eol_d;
  logic          can_load, acc, restart, word_in, at_origin;
  logic          wc_last, exp_last, sof_bad, eol_bad, emit;
  logic          unused_tkeep;

  assign unused_tkeep = ^in_stream_tkeep;

  assign can_load         = !pix_vld_q || pix_ready;
  assign in_stream_tready = aresetn && can_load && (state_q != FLUSH);
  assign acc              = in_stream_tvalid && in_stream_tready;
  assign restart          = acc && in_stream_tuser;
  // WAIT_SOF swallows everything except a frame-start word.
  assign word_in          = acc && ((state_q != WAIT_SOF) || in_stream_tuser);
  assign at_origin        = (cx_q == '0) && (cy_q == '0);
  assign sof_bad          = restart && ((state_q == PH1) || (state_q == PH2) ||
                                        ((state_q == PH0) && !at_origin));
  assign exp_last         = !restart && wc_last;
  assign eol_bad          = word_in && (in_stream_tlast != exp_last);

  line_word_counter #(
    .WORDS(words_per_line(X_SIZE))
  ) u_line_word_counter (
    .clk_i (aclk),
    .rst_ni(aresetn),
    .inc_i (word_in),
    .sof_i (restart),
    .last_o(wc_last)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    pix_d        = pix_q;
    pix_vld_d    = pix_vld_q && !pix_ready;
    x_d          = x_q;
    y_d          = y_q;
    sof_d        = sof_q;
    eol_d        = eol_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    emit         = 1'b0;
    emit_pix     = pix_q;
    pos_x        = restart ? 10'd0 : cx_q;
    pos_y        = restart ? 9'd0 : cy_q;
    frame_done_d = pix_vld_q && pix_ready && (x_q == X_LAST) && (y_q == Y_LAST);
    err_sof_d    = (err_sof_q && !clr_err) || sof_bad;
    err_eol_d    = (err_eol_q && !clr_err) || eol_bad;

    if (word_in) begin
      emit = 1'b1;
      if (restart || (state_q == PH0)) begin
        emit_pix = pixel_t'(in_stream_tdata[23:0]);
        hold_d   = {16'h0, in_stream_tdata[31:24]};
        state_d  = PH1;
      end else if (state_q == PH1) begin
        emit_pix = pixel_t'({in_stream_tdata[15:0], hold_q[7:0]});
        hold_d   = {8'h0, in_stream_tdata[31:16]};
        state_d  = PH2;
      end else begin
        emit_pix = pixel_t'({in_stream_tdata[7:0], hold_q[15:0]});
        hold_d   = in_stream_tdata[31:8];
        state_d  = FLUSH;
      end
      // A tuser restart keeps the stream locked even if tlast was also wrong.
      if (eol_bad && !sof_bad) state_d = WAIT_SOF;
    end else if ((state_q == FLUSH) && can_load) begin
      emit     = 1'b1;
      emit_pix = pixel_t'(hold_q);
      state_d  = PH0;
    end

    if (emit) begin
      pix_vld_d = 1'b1;
      pix_d     = emit_pix;
      x_d       = pos_x;
      y_d       = pos_y;
      sof_d     = (pos_x == '0) && (pos_y == '0);
      eol_d     = (pos_x == X_LAST);
      if (pos_x == X_LAST) begin
        cx_d = '0;
        cy_d = (pos_y == Y_LAST) ? 9'd0 : pos_y + 9'd1;
      end else begin
        cx_d = pos_x + 10'd1;
        cy_d = pos_y;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= WAIT_SOF;
      hold_q       <= '0;
      pix_q        <= '0;
      pix_vld_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
      err_eol_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      pix_q        <= pix_d;
      pix_vld_q    <= pix_vld_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      frame_done_q <= frame_done_d;
      err_sof_q    <= err_sof_d;
      err_eol_q    <= err_eol_d;
    end
  end

`ifdef UNPACKER_ERR_CNT_EN
  logic [15:0] sof_cnt_q, eol_cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sof_cnt_q <= '0;
      eol_cnt_q <= '0;
    end else begin
      sof_cnt_q <= err_cnt_next(sof_cnt_q, clr_err, sof_bad);
      eol_cnt_q <= err_cnt_next(eol_cnt_q, clr_err, eol_bad);
    end
  end

  assign err_sof_cnt = sof_cnt_q;
  assign err_eol_cnt = eol_cnt_q;
`endif

  assign r          = pix_q.r;
  assign g          = pix_q.g;
  assign b          = pix_q.b;
  assign x          = x_q;
  assign y          = y_q;
  assign pix_sof    = sof_q;
  assign pix_eol    = eol_q;
  assign pix_valid  = pix_vld_q;
  assign frame_done = frame_done_q;
  assign err_sof    = err_sof_q;
  assign err_eol    = err_eol_q;
endmodule

// File: tb/tb_stream_pixel_unpacker.sv
// Bench for stream_pixel_unpacker on a reduced 16x4 frame: random pixels packed into words,
// expected pixel stream derived from the packing and framing rules.
module tb_stream_pixel_unpacker;
  localparam int X   = 16;
  localparam int Y   = 4;
  localparam int WPL = X * 3 / 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = 4'hF;
  logic        tlast = 1'b0, tuser = 1'b0, tvalid = 1'b0, tready;
  logic [7:0]  r, g, b;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        pix_sof, pix_eol, pix_valid, frame_done, err_sof, err_eol;
  logic        pix_ready = 1'b0, clr_err = 1'b0;
`ifdef UNPACKER_ERR_CNT_EN
  logic [15:0] err_sof_cnt, err_eol_cnt;
`endif

  always #5 aclk = ~aclk;

  stream_pixel_unpacker #(.X_SIZE(X), .Y_SIZE(Y)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_stream_tdata(tdata), .in_stream_tkeep(tkeep), .in_stream_tlast(tlast),
    .in_stream_tuser(tuser), .in_stream_tvalid(tvalid), .in_stream_tready(tready),
    .r(r), .g(g), .b(b), .x(x), .y(y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done),
    .err_sof(err_sof), .err_eol(err_eol), .clr_err(clr_err)
`ifdef UNPACKER_ERR_CNT_EN
    , .err_sof_cnt(err_sof_cnt), .err_eol_cnt(err_eol_cnt)
`endif
  );

  typedef struct packed {logic [31:0] d; logic u; logic l;} word_t;
  typedef struct packed {logic [23:0] p; logic [9:0] x; logic [8:0] y;} epix_t;

  word_t wq[$];
  epix_t eq[$];
  int    checks = 0;
  int    failures = 0;
  int    low;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the words of one line (possibly cut short or with a wrong tlast at bad_k)
  // and the pixels those words are able to deliver.
  task automatic add_line(input int yy, input bit sof, input int nwords, input int bad_k,
                          input bit fixed);
    logic [23:0] px[X];
    logic [31:0] w[WPL];
    word_t       wt;
    epix_t       e;
    int          kend, npx;
    for (int i = 0; i < X; i++) px[i] = 24'($urandom);
    if (fixed) begin
      px[0]      = 24'h112233;
      px[1][7:0] = 8'h33;
    end
    for (int gi = 0; gi < X / 4; gi++) begin
      w[3*gi]   = {px[4*gi+1][7:0], px[4*gi]};
      w[3*gi+1] = {px[4*gi+2][15:0], px[4*gi+1][23:8]};
      w[3*gi+2] = {px[4*gi+3], px[4*gi+2][23:16]};
    end
    for (int k = 0; k < nwords; k++) begin
      wt.d = w[k];
      wt.u = sof && (k == 0);
      wt.l = (k == WPL - 1) != (k == bad_k);
      wq.push_back(wt);
    end
    kend = nwords - 1;
    if ((kend % 3 == 2) && (bad_k < 0)) npx = 4 * (kend / 3) + 4;
    else                                 npx = 4 * (kend / 3) + kend % 3 + 1;
    for (int i = 0; i < npx; i++) begin
      e.p = px[i];
      e.x = 10'(i);
      e.y = 9'(yy);
      eq.push_back(e);
    end
  endtask

  task automatic add_frame(input bit fixed);
    for (int l = 0; l < Y; l++) add_line(l, l == 0, WPL, -1, fixed && (l == 0));
  endtask

  task automatic run(input int rdy_pct, input int vld_pct, output int low_cnt);
    int    idx, guard, tail;
    logic  fd_exp, wacc, pacc;
    epix_t e;
    idx = 0; guard = 0; tail = 0; fd_exp = 1'b0; low_cnt = 0;
    while (tail < 4 && guard < 5000) begin
      @(negedge aclk);
      chk("frame_done", 64'(frame_done), 64'(fd_exp));
      fd_exp    = 1'b0;
      pix_ready = ($urandom_range(99) < rdy_pct);
      if (idx < wq.size() && $urandom_range(99) < vld_pct) begin
        tvalid = 1'b1; tdata = wq[idx].d; tuser = wq[idx].u; tlast = wq[idx].l;
      end else begin
        tvalid = 1'b0; tdata = $urandom; tuser = 1'b0; tlast = 1'b0;
      end
      #1;
      wacc = tvalid && tready;
      pacc = pix_valid && pix_ready;
      if (tvalid && !tready) low_cnt++;
      if (pix_valid && !pix_ready) chk("tready_stall", 64'(tready), 64'd0);
      if (pacc) begin
        if (eq.size() == 0) chk("extra_pixel", 64'(pix_valid), 64'd0);
        else begin
          e = eq.pop_front();
          chk("pixel", {19'd0, r, g, b, x, y, pix_sof, pix_eol},
              {19'd0, e.p, e.x, e.y, (e.x == 10'd0) && (e.y == 9'd0), e.x == 10'(X - 1)});
          fd_exp = (e.x == 10'(X - 1)) && (e.y == 9'(Y - 1));
        end
      end
      @(posedge aclk);
      if (wacc) idx++;
      if (idx >= wq.size() && eq.size() == 0) tail++;
      guard++;
    end
    chk("words_sent", 64'(idx), 64'(wq.size()));
    chk("pixels_left", 64'(eq.size()), 64'd0);
    wq.delete();
    eq.delete();
  endtask

  task automatic pulse_clr();
    @(negedge aclk); clr_err = 1'b1;
    @(negedge aclk); clr_err = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge aclk);
    #1 chk("rst_tready", 64'(tready), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk); #1;
    chk("rst_valid", 64'(pix_valid), 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_sof", 64'(pix_sof), 64'd0);
    chk("rst_eol", 64'(pix_eol), 64'd0);
    chk("rst_fdone", 64'(frame_done), 64'd0);
    chk("rst_errs", 64'({err_sof, err_eol}), 64'd0);
    chk("wait_sof_tready", 64'(tready), 64'd1);
`ifdef UNPACKER_ERR_CNT_EN
    chk("rst_cnts", 64'({err_sof_cnt, err_eol_cnt}), 64'd0);
`endif

    // Full-rate frame, first word 0x33112233
    add_frame(1'b1);
    run(100, 100, low);
    chk("flush_cycles", 64'(low), 64'(X * Y * 3 / 4 / 3 - 1));
    chk("clean_errs", 64'({err_sof, err_eol}), 64'd0);

    // Random output stalls and input gaps
    add_frame(1'b0);
    add_frame(1'b0);
    run(50, 70, low);
    chk("random_errs", 64'({err_sof, err_eol}), 64'd0);

    // Early tlast on word 5 of line 3, junk until the next tuser
    for (int l = 0; l < Y - 1; l++) add_line(l, l == 0, WPL, -1, 1'b0);
    add_line(Y - 1, 1'b0, 6, 5, 1'b0);
    for (int k = 0; k < 7; k++) wq.push_back(word_t'({$urandom, 1'b0, 1'($urandom)}));
    add_frame(1'b0);
    run(80, 90, low);
    chk("eol_err", 64'(err_eol), 64'd1);
    chk("eol_no_sof", 64'(err_sof), 64'd0);
    pulse_clr();
    chk("clr_eol", 64'({err_sof, err_eol}), 64'd0);

    // Unexpected tuser on word 7 of line 0
    add_line(0, 1'b1, 7, -1, 1'b0);
    add_frame(1'b0);
    run(70, 90, low);
    chk("sof_err", 64'(err_sof), 64'd1);
    chk("sof_no_eol", 64'(err_eol), 64'd0);
`ifdef UNPACKER_ERR_CNT_EN
    chk("sof_cnt", 64'(err_sof_cnt), 64'd1);
    chk("eol_cnt_cleared", 64'(err_eol_cnt), 64'd0);
`endif
    pulse_clr();
    chk("clr_sof", 64'(err_sof), 64'd0);
`ifdef UNPACKER_ERR_CNT_EN
    chk("clr_sof_cnt", 64'(err_sof_cnt), 64'd0);
`endif

    // Reset while holding the fourth pixel of a group
    @(negedge aclk);
    pix_ready = 1'b1; tvalid = 1'b1; tuser = 1'b1; tlast = 1'b0; tdata = $urandom;
    @(negedge aclk); tuser = 1'b0; tdata = $urandom;
    @(negedge aclk); tdata = $urandom;
    @(negedge aclk); tvalid = 1'b0;
    #1;
    chk("flush_tready", 64'(tready), 64'd0);
    chk("flush_x", 64'(x), 64'd2);
    aresetn = 1'b0;
    @(negedge aclk); #1;
    chk("mid_rst_tready", 64'(tready), 64'd0);
    chk("mid_rst_valid", 64'(pix_valid), 64'd0);
    chk("mid_rst_xy", 64'({x, y}), 64'd0);
    chk("mid_rst_flags", 64'({pix_sof, pix_eol, frame_done, err_sof, err_eol}), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk); #1;
    chk("no_held_pixel", 64'(pix_valid), 64'd0);

    // Resynchronised frame after reset
    add_frame(1'b0);
    run(60, 80, low);
    chk("final_errs", 64'({err_sof, err_eol}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
